pipeline_stall_controller: RTL
==============================

// Module: pipeline_stall_controller
// PURPOSE
//  Central stall/flush sequencer for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
//  Merges four hazard sources into per-stage hold/bubble controls: load-use (from hazard detection),
//  taken branch in EX, the multi-cycle mul/div unit and the data-memory wait.
//  Owns the mul/div latency count and the memory-wait timeout.
// PARAMETERS
//  MD_LATENCY   default 4    mul/div cycles from issue to result; legal range >=1
//  MEM_TIMEOUT  default 255  max MEM_WAIT cycles before forced exit and mem_timeout_err
// PORTS
//  clk            in   1   single clock; all state updates on rising edge
//  rst_n          in   1   synchronous, active-low reset
//  load_use       in   1   load-use hazard detected for the ID instruction
//  branch_taken   in   1   EX holds a taken branch/jump; younger stages are wrong-path
//  md_start       in   1   EX holds a mul/div instruction (level, qualified by state)
//  mem_req        in   1   MEM holds a load/store
//  dmem_ready     in   1   data memory completes the access this cycle
//  pc_stall       out  1   hold PC
//  if_id_stall    out  1   hold IF/ID register
//  if_id_flush    out  1   clear IF/ID to NOP
//  id_ex_stall    out  1   hold ID/EX register
//  id_ex_bubble   out  1   load NOP control into ID/EX
//  ex_mem_stall   out  1   hold EX/MEM register
//  ex_mem_bubble  out  1   load NOP into EX/MEM
//  mem_wb_bubble  out  1   load NOP into MEM/WB
//  md_done        out  1   one-cycle pulse: mul/div result valid, EX/MEM captures it
//  mem_timeout_err out 1   sticky; set on MEM_WAIT timeout, cleared only by reset
//  stall_cycles   out  32  cycles with pc_stall=1 (STALL_STATS_EN only)
//  flush_count    out  32  cycles with if_id_flush=1 (STALL_STATS_EN only)
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state=RUN, counters=0, mem_timeout_err=0.
//    All outputs are 0 in the cycle after reset, regardless of any in-flight operation.
//  - Outputs are combinational from the registered state and the current inputs.
//    Transitions are registered.
//  - States: RUN, MD_WAIT, MEM_WAIT.
//  - RUN, priority high to low:
//    1) mem_req & !dmem_ready: freeze the whole pipeline.
//       pc/if_id/id_ex/ex_mem_stall=1, mem_wb_bubble=1; next MEM_WAIT; tmo_cnt<=0.
//    2) md_start: pc/if_id/id_ex_stall=1, ex_mem_bubble=1.
//       If MD_LATENCY>1: next MD_WAIT, md_cnt<=MD_LATENCY-2.
//       If MD_LATENCY==1: stay RUN, md_done next cycle.
//    3) branch_taken: if_id_flush=1, id_ex_bubble=1. Branch beats load_use, so no stall.
//    4) load_use: pc_stall=1, if_id_stall=1, id_ex_bubble=1.
//  - MD_WAIT:
//    Same outputs as RUN case 2; md_cnt decrements.
//    At md_cnt==0, next RUN and md_done pulses in the first RUN cycle.
//    Net effect: frozen MD_LATENCY cycles total; md_done asserted in cycle t+MD_LATENCY for issue at cycle t.
//    In the md_done cycle md_start is ignored, so the same instruction is not reissued.
//    mem_req, load_use and branch_taken are ignored in MD_WAIT (MEM holds a bubble; ID/EX frozen).
//  - MEM_WAIT:
//    Freeze outputs as RUN case 1; tmo_cnt increments.
//    On dmem_ready: no stalls that cycle, next RUN.
//    On tmo_cnt==MEM_TIMEOUT-1 without ready: set mem_timeout_err, release as if ready, next RUN.
//    branch_taken is held frozen in EX and is acted on after release.
//  - Counters saturate; never wrap. md_cnt width is $clog2(MD_LATENCY+1); tmo_cnt width is $clog2(MEM_TIMEOUT+1).
// CONFIGURATION
//  STALL_STATS_EN defined:
//    stall_cycles and flush_count increment per qualifying cycle, saturate at 32'hFFFF_FFFF, reset to 0.
//  STALL_STATS_EN undefined:
//    both ports tied to 32'd0; no counter flops are built.
// STRUCTURE
//  Package pipe_ctrl_pkg holds:
//    state enum {RUN, MD_WAIT, MEM_WAIT} (2-bit encoding)
//    the NOP/bubble control constants shared with the pipeline registers
//  Sub-module stall_cycle_counter: 32-bit saturating counter with enable and sync active-low clear.
//    Instantiated twice under STALL_STATS_EN.
// TESTING
//  1) Reset: hold rst_n=0 with md_start=1 and mem_req=1 -> all outputs 0; state RUN after release.
//  2) load_use=1 for 1 cycle in RUN -> pc_stall=1, if_id_stall=1, id_ex_bubble=1 for exactly 1 cycle.
//  3) branch_taken=1 and load_use=1 together -> if_id_flush=1, id_ex_bubble=1, pc_stall=0.
//  4) MD_LATENCY=4, md_start at cycle 10 -> stalls in cycles 10-13; md_done=1 only at cycle 14; no reissue.
//  5) mem_req=1, dmem_ready low 3 cycles then high -> full freeze 3 cycles; release on the 4th; err stays 0.
//  6) MEM_TIMEOUT=8, dmem_ready never asserted -> freeze 8 cycles; mem_timeout_err=1 sticky; return to RUN.
//     With STALL_STATS_EN, stall_cycles==8.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
//   state_e       : sequencer states (2-bit encoding)
//   stall_ctrl_t  : per-stage hold/bubble/flush control bundle
//   CTRL_*        : control bundles for each hazard response
//   NOP_INSTR     : instruction word the pipeline registers load on flush/bubble
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_bubble;
    logic ex_mem_stall;
    logic ex_mem_bubble;
    logic mem_wb_bubble;
  } stall_ctrl_t;

  // sll $0,$0,0 -- the canonical MIPS NOP loaded by a flushed/bubbled register
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Field order: pc, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble,
  //              ex_mem_stall, ex_mem_bubble, mem_wb_bubble
  localparam stall_ctrl_t CTRL_NONE     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  // Data memory busy: hold everything up to EX/MEM, drain a NOP into WB.
  localparam stall_ctrl_t CTRL_FREEZE   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  // Mul/div busy: hold front end and EX, feed NOPs into MEM.
  localparam stall_ctrl_t CTRL_MD       = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  // Taken branch: kill the two wrong-path instructions in IF/ID and ID.
  localparam stall_ctrl_t CTRL_BRANCH   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  // Load-use: hold PC and IF/ID one cycle, insert one bubble into EX.
  localparam stall_ctrl_t CTRL_LOAD_USE = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

endpackage

// File: rtl/stall_cycle_counter.sv
// 32-bit saturating event counter.
//   clk    : clock
//   clr_n  : synchronous active-low clear
//   en     : count this cycle
//   count  : current count, sticks at 32'hFFFF_FFFF
module stall_cycle_counter (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        en,
  output logic [31:0] count
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage MIPS pipeline.
// Merges load-use, taken-branch, mul/div and data-memory-wait hazards into
// per-stage hold/bubble/flush controls; owns the mul/div latency count and
// the memory-wait timeout.
// Parameters: MD_LATENCY (>=1, mul/div cycles), MEM_TIMEOUT (>=1, max wait cycles)
// Ports:
//   clk, rst_n (sync, active-low)
//   load_use, branch_taken, md_start, mem_req, dmem_ready  : hazard inputs
//   pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble,
//   ex_mem_stall, ex_mem_bubble, mem_wb_bubble              : stage controls
//   md_done          : one-cycle mul/div result-valid pulse
//   mem_timeout_err  : sticky memory-wait timeout flag
//   stall_cycles, flush_count : statistics, live only with STALL_STATS_EN defined
module pipeline_stall_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_LATENCY  = 4,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_use,
  input  logic        branch_taken,
  input  logic        md_start,
  input  logic        mem_req,
  input  logic        dmem_ready,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_stall,
  output logic        id_ex_bubble,
  output logic        ex_mem_stall,
  output logic        ex_mem_bubble,
  output logic        mem_wb_bubble,
  output logic        md_done,
  output logic        mem_timeout_err,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  localparam int MD_W      = $clog2(MD_LATENCY + 1);
  localparam int TMO_W     = $clog2(MEM_TIMEOUT + 1);
  localparam int MD_LOAD_I = (MD_LATENCY > 1) ? (MD_LATENCY - 2) : 0;

  localparam logic [MD_W-1:0]  MD_LOAD  = MD_W'(MD_LOAD_I);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  state_e             state_q,   state_d;
  logic [MD_W-1:0]    md_cnt_q,  md_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               md_done_q, md_done_d;
  logic               err_q,     err_d;
  stall_ctrl_t        ctrl;
  stall_ctrl_t        ctrl_out;

  always_comb begin
    state_d   = state_q;
    md_cnt_d  = md_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    md_done_d = 1'b0;
    err_d     = err_q;
    ctrl      = CTRL_NONE;

    unique case (state_q)
      RUN: begin
        if (mem_req && !dmem_ready) begin
          ctrl      = CTRL_FREEZE;
          state_d   = MEM_WAIT;
          tmo_cnt_d = '0;
        end else if (md_start && !md_done_q) begin
          // md_start is a level; in the md_done cycle EX still holds the
          // finished mul/div, so it must not be issued again.
          ctrl = CTRL_MD;
          if (MD_LATENCY > 1) begin
            state_d  = MD_WAIT;
            md_cnt_d = MD_LOAD;
          end else begin
            md_done_d = 1'b1;
          end
        end else if (branch_taken) begin
          ctrl = CTRL_BRANCH;
        end else if (load_use) begin
          ctrl = CTRL_LOAD_USE;
        end
      end

      MD_WAIT: begin
        ctrl = CTRL_MD;
        if (md_cnt_q == '0) begin
          state_d   = RUN;
          md_done_d = 1'b1;
        end else begin
          md_cnt_d = md_cnt_q - 1'b1;
        end
      end

      MEM_WAIT: begin
        if (dmem_ready || (tmo_cnt_q == TMO_LAST)) begin
          // Release cycle: the frozen EX instruction advances now, so a
          // taken branch held there must flush its wrong-path followers here.
          if (!dmem_ready) begin
            err_d = 1'b1;
          end
          if (branch_taken) begin
            ctrl = CTRL_BRANCH;
          end
          state_d = RUN;
        end else begin
          ctrl = CTRL_FREEZE;
          if (tmo_cnt_q != '1) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RUN;
      md_cnt_q  <= '0;
      tmo_cnt_q <= '0;
      md_done_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      md_cnt_q  <= md_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      md_done_q <= md_done_d;
      err_q     <= err_d;
    end
  end

  // While reset is asserted the pipeline must see no controls at all, even
  // though the hazard inputs may still reflect an in-flight operation.
  assign ctrl_out        = rst_n ? ctrl : CTRL_NONE;
  assign pc_stall        = ctrl_out.pc_stall;
  assign if_id_stall     = ctrl_out.if_id_stall;
  assign if_id_flush     = ctrl_out.if_id_flush;
  assign id_ex_stall     = ctrl_out.id_ex_stall;
  assign id_ex_bubble    = ctrl_out.id_ex_bubble;
  assign ex_mem_stall    = ctrl_out.ex_mem_stall;
  assign ex_mem_bubble   = ctrl_out.ex_mem_bubble;
  assign mem_wb_bubble   = ctrl_out.mem_wb_bubble;
  assign md_done         = rst_n & md_done_q;
  assign mem_timeout_err = rst_n & err_q;

`ifdef STALL_STATS_EN
  stall_cycle_counter u_stall_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .en    (pc_stall),
    .count (stall_cycles)
  );

  stall_cycle_counter u_flush_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .en    (if_id_flush),
    .count (flush_count)
  );
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
`endif

endmodule
